// File: rtl/gb_if_initiator.sv
// GB-side initiator for the GB-to-IF transfer protocol: cfg handshake, then a
// fixed-length read or write burst, with a 2-entry read buffer toward the client.
module gb_if_initiator #(
  parameter int PORT_WIDTH = 128,
  parameter int LEN_T0     = 64,
  parameter int LEN_T1     = 64,
  parameter int LEN_T2     = 64,
  parameter int LEN_T3     = 54,
  parameter int LEN_BULK   = 512,
  parameter int CNT_W      = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_val,
  output logic                  req_rdy,
  input  logic [3:0]            req_info,
  output logic                  GBIF_cfg_val,
  input  logic                  IFGB_cfg_rdy,
  output logic [3:0]            GBIF_cfg_info,
  output logic                  GBIF_wr_val,
  input  logic                  IFGB_wr_rdy,
  output logic [PORT_WIDTH-1:0] GBIF_wr_data,
  input  logic                  IFGB_rd_val,
  output logic                  GBIF_rd_rdy,
  input  logic [PORT_WIDTH-1:0] IFGB_rd_data,
  input  logic                  cli_wr_val,
  output logic                  cli_wr_rdy,
  input  logic [PORT_WIDTH-1:0] cli_wr_data,
  output logic                  cli_rd_val,
  input  logic                  cli_rd_rdy,
  output logic [PORT_WIDTH-1:0] cli_rd_data,
  output logic                  cli_rd_last,
  output logic                  xfer_done,
  output logic [2:0]            xfer_type
);

  typedef enum logic [2:0] {S_IDLE, S_CFG, S_RD, S_WR, S_DRAIN, S_DONE} state_t;

  state_t                state;
  logic [3:0]            info;
  logic [CNT_W-1:0]      cnt;
  logic [CNT_W-1:0]      last_idx;
  logic                  cfg_val_q;
  logic                  rd_rdy_q;
  logic                  done_q;
  logic [2:0]            done_type_q;

  logic [PORT_WIDTH-1:0] fifo_data [2];
  logic [1:0]            fifo_last;
  logic [1:0]            fifo_cnt;
  logic [1:0]            fifo_cnt_next;

  logic push, pop, push_last, wr_hs;

  function automatic logic [CNT_W-1:0] last_beat(input logic [2:0] t);
    case (t)
      3'd0:    last_beat = CNT_W'(LEN_T0 - 1);
      3'd1:    last_beat = CNT_W'(LEN_T1 - 1);
      3'd2:    last_beat = CNT_W'(LEN_T2 - 1);
      3'd3:    last_beat = CNT_W'(LEN_T3 - 1);
      default: last_beat = CNT_W'(LEN_BULK - 1);
    endcase
  endfunction

  assign push          = (state == S_RD) && IFGB_rd_val && rd_rdy_q;
  assign push_last     = (cnt == last_idx);
  assign pop           = cli_rd_val && cli_rd_rdy;
  assign wr_hs         = (state == S_WR) && cli_wr_val && IFGB_wr_rdy;
  assign fifo_cnt_next = fifo_cnt + {1'b0, push} - {1'b0, pop};

  assign req_rdy       = (state == S_IDLE);
  assign GBIF_cfg_val  = cfg_val_q;
  assign GBIF_cfg_info = info;
  assign GBIF_rd_rdy   = rd_rdy_q;
  assign GBIF_wr_val   = (state == S_WR) && cli_wr_val;
  assign GBIF_wr_data  = (state == S_WR) ? cli_wr_data : '0;
  assign cli_wr_rdy    = (state == S_WR) && IFGB_wr_rdy;
  assign cli_rd_val    = (fifo_cnt != 2'd0);
  assign cli_rd_data   = fifo_data[0];
  assign cli_rd_last   = cli_rd_val && fifo_last[0];
  assign xfer_done     = done_q;
  assign xfer_type     = done_type_q;

  // Head-at-slot-0 buffer: a pop shifts slot 1 forward, a push lands in the
  // first slot that will be free after this cycle's pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: storage is reset too so cli_rd_data reads 0 out of reset rather than X.
      fifo_cnt     <= '0;
      fifo_last    <= '0;
      fifo_data[0] <= '0;
      fifo_data[1] <= '0;
    end else begin
      fifo_cnt <= fifo_cnt_next;
      if (pop && fifo_cnt == 2'd2) begin
        fifo_data[0] <= fifo_data[1];
        fifo_last[0] <= fifo_last[1];
      end
      if (push) begin
        if (fifo_cnt == 2'd0 || pop) begin
          fifo_data[0] <= IFGB_rd_data;
          fifo_last[0] <= push_last;
        end else begin
          fifo_data[1] <= IFGB_rd_data;
          fifo_last[1] <= push_last;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      info        <= '0;
      cnt         <= '0;
      last_idx    <= '0;
      cfg_val_q   <= 1'b0;
      rd_rdy_q    <= 1'b0;
      done_q      <= 1'b0;
      done_type_q <= '0;
    end else begin
      done_q   <= 1'b0;
      rd_rdy_q <= 1'b0;
      case (state)
        S_IDLE: if (req_val) begin
          info      <= req_info;
          last_idx  <= last_beat(req_info[3:1]);
          cfg_val_q <= 1'b1;
          state     <= S_CFG;
        end
        S_CFG: if (IFGB_cfg_rdy) begin
          cfg_val_q <= 1'b0;
          cnt       <= '0;
          if (info[0]) begin
            rd_rdy_q <= 1'b1;
            state    <= S_RD;
          end else begin
            state    <= S_WR;
          end
        end
        S_RD: begin
          // Ready only if a push next cycle cannot land on a full buffer.
          rd_rdy_q <= (fifo_cnt_next <= 2'd1) && !(push && push_last);
          if (push) begin
            if (push_last) state <= S_DRAIN;
            else           cnt   <= cnt + CNT_W'(1);
          end
        end
        S_WR: if (wr_hs) begin
          if (push_last) begin
            done_q      <= 1'b1;
            done_type_q <= info[3:1];
            state       <= S_DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        S_DRAIN: if (fifo_cnt_next == 2'd0) begin
          done_q      <= 1'b1;
          done_type_q <= info[3:1];
          state       <= S_DONE;
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gb_if_initiator.sv
// Randomized bench for gb_if_initiator: an IF responder and client model drive
// transfers; a beat scoreboard tracks occupancy, ordering, last flag and counts.
module tb_gb_if_initiator;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_val, req_rdy;
  logic [3:0]   req_info;
  logic         GBIF_cfg_val, IFGB_cfg_rdy;
  logic [3:0]   GBIF_cfg_info;
  logic         GBIF_wr_val, IFGB_wr_rdy;
  logic [127:0] GBIF_wr_data;
  logic         IFGB_rd_val, GBIF_rd_rdy;
  logic [127:0] IFGB_rd_data;
  logic         cli_wr_val, cli_wr_rdy;
  logic [127:0] cli_wr_data;
  logic         cli_rd_val, cli_rd_rdy;
  logic [127:0] cli_rd_data;
  logic         cli_rd_last, xfer_done;
  logic [2:0]   xfer_type;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [127:0] data;
    logic         last;
  } beat_t;
  beat_t exp_q[$];

  gb_if_initiator dut (
    .clk(clk), .rst(rst),
    .req_val(req_val), .req_rdy(req_rdy), .req_info(req_info),
    .GBIF_cfg_val(GBIF_cfg_val), .IFGB_cfg_rdy(IFGB_cfg_rdy), .GBIF_cfg_info(GBIF_cfg_info),
    .GBIF_wr_val(GBIF_wr_val), .IFGB_wr_rdy(IFGB_wr_rdy), .GBIF_wr_data(GBIF_wr_data),
    .IFGB_rd_val(IFGB_rd_val), .GBIF_rd_rdy(GBIF_rd_rdy), .IFGB_rd_data(IFGB_rd_data),
    .cli_wr_val(cli_wr_val), .cli_wr_rdy(cli_wr_rdy), .cli_wr_data(cli_wr_data),
    .cli_rd_val(cli_rd_val), .cli_rd_rdy(cli_rd_rdy), .cli_rd_data(cli_rd_data),
    .cli_rd_last(cli_rd_last), .xfer_done(xfer_done), .xfer_type(xfer_type)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int len_of(input logic [2:0] t);
    if (t <= 3'd2) return 64;
    if (t == 3'd3) return 54;
    return 512;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic idle_inputs();
    req_val      = 1'b0;
    req_info     = '0;
    IFGB_cfg_rdy = 1'b0;
    IFGB_wr_rdy  = 1'b0;
    IFGB_rd_val  = 1'b0;
    IFGB_rd_data = '0;
    cli_wr_val   = 1'b0;
    cli_wr_data  = '0;
    cli_rd_rdy   = 1'b0;
  endtask

  // One transfer from request to done; abort_at >= 0 pulses rst after that many
  // accepted read beats, chain_out holds req_val high into the next request.
  task automatic do_xfer(input logic [3:0] info, input int p_if, input int p_cli,
                         input int cfg_delay, input int stall_at, input int stall_len,
                         input int abort_at, input bit chain_in, input bit chain_out,
                         input logic [3:0] next_info);
    int           len, accepted, delivered, wr_hs, stalled, cyc, occ, gap;
    bit           is_rd, saw_full, done_seen;
    logic [127:0] cur_word;
    beat_t        b;
    len       = len_of(info[3:1]);
    is_rd     = info[0];
    accepted  = 0;
    delivered = 0;
    wr_hs     = 0;
    stalled   = 0;
    saw_full  = 0;
    done_seen = 0;
    cur_word  = rnd128();
    exp_q.delete();

    if (!chain_in) begin
      cyc = 0;
      while (!req_rdy && cyc < 20) begin
        @(negedge clk);
        cyc++;
      end
      check("req_rdy_idle", req_rdy, 1);
      req_val  = 1'b1;
      req_info = info;
      @(negedge clk);
      check("cfg_latency", GBIF_cfg_val, 1);
    end
    req_val = 1'b0;

    for (int i = 0; i <= cfg_delay; i++) begin
      check("cfg_val_hold", GBIF_cfg_val, 1);
      check("cfg_info", GBIF_cfg_info, info);
      if (i == cfg_delay) IFGB_cfg_rdy = 1'b1;
      @(negedge clk);
    end
    IFGB_cfg_rdy = 1'b0;
    check("cfg_val_drop", GBIF_cfg_val, 0);

    cyc = 0;
    while (cyc < 8000) begin
      if (xfer_done) begin
        done_seen = 1;
        break;
      end
      if (abort_at >= 0 && accepted == abort_at) begin
        idle_inputs();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_req_rdy", req_rdy, 1);
        check("rst_cfg_val", GBIF_cfg_val, 0);
        check("rst_rd_rdy", GBIF_rd_rdy, 0);
        check("rst_fifo_empty", cli_rd_val, 0);
        check("rst_rd_last", cli_rd_last, 0);
        check("rst_wr_val", GBIF_wr_val, 0);
        check("rst_done", xfer_done, 0);
        for (int k = 0; k < 4; k++) begin
          @(negedge clk);
          check("no_done_after_rst", xfer_done, 0);
        end
        return;
      end

      occ = accepted - delivered;
      check("fifo_occ_le2", occ <= 2, 1);
      check("cli_rd_val", cli_rd_val, occ != 0);
      if (is_rd && occ == 2) begin
        saw_full = 1;
        check("rd_rdy_when_full", GBIF_rd_rdy, 0);
      end
      if (!is_rd) check("rd_rdy_in_wr", GBIF_rd_rdy, 0);

      IFGB_rd_val  = is_rd ? ($urandom_range(99) < p_if) : 1'($urandom_range(1));
      IFGB_rd_data = rnd128();
      cli_rd_rdy   = ($urandom_range(99) < p_cli);
      if (is_rd && stall_len > 0 && accepted >= stall_at && stalled < stall_len) begin
        cli_rd_rdy = 1'b0;
        stalled++;
      end
      IFGB_wr_rdy = !is_rd && ($urandom_range(99) < p_if);
      cli_wr_val  = !is_rd && ($urandom_range(99) < p_cli);
      cli_wr_data = cur_word;
      #1;

      if (cli_rd_val && cli_rd_rdy) begin
        if (exp_q.size() == 0) begin
          check("rd_extra_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          check("rd_data", cli_rd_data, b.data);
          check("rd_last", cli_rd_last, b.last);
          delivered++;
        end
      end
      if (IFGB_rd_val && GBIF_rd_rdy) begin
        if (!is_rd || accepted >= len) begin
          check("rd_accept_unexpected", 1, 0);
        end else begin
          exp_q.push_back('{IFGB_rd_data, accepted == len - 1});
          accepted++;
        end
      end
      if (cli_wr_val && cli_wr_rdy) begin
        check("wr_rdy_pass", IFGB_wr_rdy, 1);
        check("wr_val", GBIF_wr_val, 1);
        check("wr_data", GBIF_wr_data, cur_word);
        wr_hs++;
        if (wr_hs > len) check("wr_over", wr_hs, len);
        cur_word = rnd128();
      end
      @(negedge clk);
      cyc++;
    end

    check("done_seen", done_seen, 1);
    idle_inputs();
    if (!done_seen) return;
    check("xfer_type", xfer_type, info[3:1]);
    if (is_rd) begin
      check("rd_beats", delivered, len);
      check("rd_accepted", accepted, len);
    end else begin
      check("wr_beats", wr_hs, len);
      cli_wr_val  = 1'b1;
      IFGB_wr_rdy = 1'b1;
      #1;
      check("wr_rdy_after_last", cli_wr_rdy, 0);
    end
    if (stall_len > 0) check("stall_filled_fifo", saw_full, 1);
    if (chain_out) begin
      req_val  = 1'b1;
      req_info = next_info;
    end
    @(negedge clk);
    check("done_pulse_width", xfer_done, 0);
    cli_wr_val  = 1'b0;
    IFGB_wr_rdy = 1'b0;
    if (chain_out) begin
      gap = 1;
      while (!GBIF_cfg_val && gap < 10) begin
        @(negedge clk);
        gap++;
      end
      check("b2b_cfg_gap", gap, 2);
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_req_rdy", req_rdy, 1);
    check("reset_cfg_val", GBIF_cfg_val, 0);
    check("reset_cfg_info", GBIF_cfg_info, 0);
    check("reset_rd_rdy", GBIF_rd_rdy, 0);
    check("reset_cli_rd_val", cli_rd_val, 0);
    check("reset_done", xfer_done, 0);
    check("reset_type", xfer_type, 0);
    rst = 1'b0;
    @(negedge clk);

    do_xfer(4'b0001, 100, 100, 3, 0, 0, -1, 1'b0, 1'b0, 4'b0000);   // type 0 read
    do_xfer(4'b0111, 50, 50, 1, 0, 0, -1, 1'b0, 1'b0, 4'b0000);     // type 3 read
    do_xfer(4'b0010, 50, 50, 0, 0, 0, -1, 1'b0, 1'b0, 4'b0000);     // type 1 write
    do_xfer(4'b1101, 100, 100, 2, 200, 100, -1, 1'b0, 1'b0, 4'b0000); // type 6 bulk, stalled client
    do_xfer(4'b0001, 100, 100, 1, 0, 0, 20, 1'b0, 1'b0, 4'b0000);   // aborted by reset
    do_xfer(4'b0001, 100, 100, 0, 0, 0, -1, 1'b0, 1'b0, 4'b0000);   // recovers after reset
    do_xfer(4'b0100, 70, 70, 0, 0, 0, -1, 1'b0, 1'b1, 4'b1011);     // type 2 write, chained
    do_xfer(4'b1011, 60, 80, 0, 0, 0, -1, 1'b1, 1'b0, 4'b0000);     // type 5 read

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/gb_if_initiator.md
Name: gb_if_initiator

Overview:
- On-chip initiator for the GB-to-IF transfer protocol; drives the GB side (GBIF_cfg_val/GBIF_cfg_info, GBIF_wr_val/GBIF_wr_data, GBIF_rd_rdy) toward the off-chip IF responder.
- Accepts one transfer request at a time from internal GB clients, runs the cfg handshake, then streams a fixed beat count per transfer type.
- Read data is buffered toward the client; write data passes through from the client.
- Emits a done pulse per transfer.

Parameters:
PORT_WIDTH   128  data port width (matches IF port)
LEN_T0       64   beats for type 0 (cfg word read)
LEN_T1       64   beats for type 1 (write)
LEN_T2       64   beats for type 2 (write)
LEN_T3       54   beats for type 3 (weight-address read)
LEN_BULK     512  beats for types 4-7 (wei data/flag, act data/flag reads)
CNT_W        10   beat counter width; must hold LEN_BULK-1

Ports:
clk            in   1           clock
rst            in   1           synchronous active-high reset
req_val        in   1           client transfer request valid
req_rdy        out  1           block idle, can accept request
req_info       in   4           [3:1]=type, [0]=direction (1=read from IF, 0=write to IF)
GBIF_cfg_val   out  1           cfg request to IF
IFGB_cfg_rdy   in   1           IF accepts cfg
GBIF_cfg_info  out  4           latched req_info
GBIF_wr_val    out  1           write beat valid
IFGB_wr_rdy    in   1           IF accepts write beat
GBIF_wr_data   out  PORT_WIDTH  write beat
IFGB_rd_val    in   1           IF read beat valid
GBIF_rd_rdy    out  1           initiator accepts read beat
IFGB_rd_data   in   PORT_WIDTH  read beat
cli_wr_val     in   1           client write beat valid
cli_wr_rdy     out  1           write beat consumed
cli_wr_data    in   PORT_WIDTH  client write beat
cli_rd_val     out  1           buffered read beat valid
cli_rd_rdy     in   1           client accepts read beat
cli_rd_data    out  PORT_WIDTH  buffered read beat
cli_rd_last    out  1           marks final beat of read transfer
xfer_done      out  1           one-cycle pulse at transfer completion
xfer_type      out  3           type of the completed transfer, valid with xfer_done

Behaviour:
- Reset:
  - state=IDLE, beat counter=0, read FIFO flushed.
  - All outputs 0 except req_rdy, which follows state (1 in IDLE).
  - Reset asserted mid-transfer aborts the transfer; no xfer_done is issued.
- States:
  - IDLE: req_rdy=1. On req_val, latch req_info and compute len from type (0→LEN_T0, 1→LEN_T1, 2→LEN_T2, 3→LEN_T3, 4-7→LEN_BULK). Next state is CFG.
  - CFG: GBIF_cfg_val=1, GBIF_cfg_info=latched info, held stable until IFGB_cfg_rdy. On the handshake cycle, go to RD if info[0]=1, else WR. Counter cleared.
  - RD:
    - GBIF_rd_rdy=1 when the FIFO has a free slot, registered from the FIFO count so there is no combinational path from cli_rd_rdy.
    - Each IFGB_rd_val&GBIF_rd_rdy pushes IFGB_rd_data plus a last flag (counter==len-1) and increments the counter.
    - On the last push, go to DRAIN.
  - WR:
    - GBIF_wr_val = cli_wr_val, GBIF_wr_data = cli_wr_data, cli_wr_rdy = IFGB_wr_rdy (combinational pass-through, gated by state==WR).
    - Each handshake increments the counter. On counter==len-1 with handshake, go to DONE.
  - DRAIN: wait until the FIFO is empty after the last pop, then go to DONE.
  - DONE: xfer_done=1 and xfer_type=info[3:1] for exactly one cycle, then IDLE.
- Read FIFO:
  - 2 entries, registered outputs; cli_rd_val = FIFO non-empty.
  - Simultaneous push and pop when full is not allowed, because rd_rdy deasserts at count≥1 with a pending push. Push and pop in the same cycle at count=1 keeps count=1.
  - Peak throughput is 1 beat/cycle when cli_rd_rdy is held high.
- Outside their states, GBIF_rd_rdy, GBIF_wr_val and cli_wr_rdy are 0. IFGB_rd_val outside RD is ignored.
- Counter compare uses len-1. Counter wraps to 0 on entry to CFG, never mid-transfer.
- Latency:
  - Request accept → GBIF_cfg_val: 1 cycle.
  - Cfg handshake → first data-phase cycle: 1 cycle.
  - Read beat accept → cli_rd_val: 1 cycle.
- A new req_val is not accepted until the cycle after xfer_done (IDLE).

Test Plan:
- Type-0 read, IFGB_cfg_rdy high after 3 cycles, rd_val and cli_rd_rdy always 1 → exactly 64 beats on cli_rd_data in order; cli_rd_last on beat 63; xfer_done with xfer_type=0; GBIF_cfg_info=4'b0001 stable for the whole CFG phase.
- Type-3 read with random rd_val and cli_rd_rdy (50%) → 54 beats with no loss or duplication; FIFO count never exceeds 2; xfer_done once.
- Type-1 write, info=4'b0010, random IFGB_wr_rdy and cli_wr_val → exactly 64 GBIF handshakes matching client data; cli_wr_rdy 0 after the 64th; xfer_done with type=1.
- Type-6 read, 512 beats, cli_rd_rdy held 0 for 100 cycles mid-stream → GBIF_rd_rdy drops while the FIFO is full; all 512 beats arrive once; counter reaches 511 without overflow.
- rst pulsed during RD at beat 20 → next cycle in IDLE with outputs 0 and FIFO empty, no xfer_done; a following type-0 request completes normally with 64 beats.
- Back-to-back requests with req_val held high → second GBIF_cfg_val rises 2 cycles after the first xfer_done (DONE→IDLE→CFG); spurious IFGB_rd_val during WR is ignored.
